// File: rtl/ula_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ula_pkg
// Description : Shared op-code encoding and flag bundle for the ULA pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package ula_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_SLT    = 4'd5,
        OP_SLTU   = 4'd6,
        OP_SLL    = 4'd7,
        OP_SRL    = 4'd8,
        OP_SRA    = 4'd9,
        OP_BEQ    = 4'd10,
        OP_BNE    = 4'd11,
        OP_BLT    = 4'd12,
        OP_PASS_A = 4'd13,
        OP_PASS_B = 4'd14,
        OP_RSVD   = 4'd15
    } op_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
        logic branch_taken;
        logic illegal;
    } flags_t;

endpackage : ula_pkg
`default_nettype wire

// File: rtl/ula_core.sv
`default_nettype none
// ============================================================================
// Module      : ula_core
// Description : Purely combinational ALU: op/a/b -> result and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ula_core
    import ula_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output flags_t           flags
);

    localparam int c_MSB = WIDTH - 1;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic             w_lt_s;
    logic             w_lt_u;
    logic             w_eq;

    assign w_sum   = {1'b0, a} + {1'b0, b};
    // The extra MSB of the unsigned difference is the borrow, i.e. a < b unsigned.
    assign w_diff  = {1'b0, a} - {1'b0, b};
    assign w_lt_u  = w_diff[WIDTH];
    assign w_lt_s  = $signed(a) < $signed(b);
    assign w_eq    = (a == b);
    assign w_shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        flags  = '0;
        case (op_e'(op))
            OP_ADD: begin
                result      = w_sum[WIDTH-1:0];
                flags.carry = w_sum[WIDTH];
                flags.ovf   = (a[c_MSB] == b[c_MSB]) && (w_sum[c_MSB] != a[c_MSB]);
            end
            OP_SUB: begin
                result      = w_diff[WIDTH-1:0];
                flags.carry = w_lt_u;
                flags.ovf   = (a[c_MSB] != b[c_MSB]) && (w_diff[c_MSB] != a[c_MSB]);
            end
            OP_AND:    result = a & b;
            OP_OR:     result = a | b;
            OP_XOR:    result = a ^ b;
            OP_SLT:    result = {{(WIDTH-1){1'b0}}, w_lt_s};
            OP_SLTU:   result = {{(WIDTH-1){1'b0}}, w_lt_u};
            OP_SLL:    result = a << w_shamt;
            OP_SRL:    result = a >> w_shamt;
            OP_SRA:    result = $signed(a) >>> w_shamt;
            OP_BEQ:    flags.branch_taken = w_eq;
            OP_BNE:    flags.branch_taken = !w_eq;
            OP_BLT:    flags.branch_taken = w_lt_s;
            OP_PASS_A: result = a;
            OP_PASS_B: result = b;
            default:   flags.illegal = 1'b1;
        endcase
        if (flags.branch_taken) begin
            result = {{(WIDTH-1){1'b0}}, 1'b1};
        end
        flags.zero = ~|result;
        flags.neg  = result[c_MSB];
    end

endmodule : ula_core
`default_nettype wire

// File: rtl/ula_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ula_pipe
// Description : Two-stage valid/ready ALU pipeline (S1 operands, S2 results).
// Revision    : 1.0 - initial release
// ============================================================================
module ula_pipe
    import ula_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             branch_taken,
    output logic             illegal
);

    logic             r_s1_valid;
    logic [3:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_result;
    flags_t           r_flags;

    logic             w_s2_load;
    logic             w_in_ready;
    logic             w_in_fire;
    logic [WIDTH-1:0] w_core_result;
    flags_t           w_core_flags;

    // Ready is built only from stage occupancy and out_ready, never from in_valid.
    assign w_s2_load  = !r_s2_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_load;
    assign w_in_fire  = in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_s1_op <= op;
            r_s1_a  <= a;
            r_s1_b  <= b;
        end
    end

    ula_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .op     (r_s1_op),
        .a      (r_s1_a),
        .b      (r_s1_b),
        .result (w_core_result),
        .flags  (w_core_flags)
    );

    // Result registers only change on a real S1->S2 transfer, so a stalled
    // output holds and a bubble leaves stale (unqualified) data behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_flags    <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_core_result;
                r_flags  <= w_core_flags;
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = r_s2_valid;
    assign result       = r_result;
    assign zero         = r_flags.zero;
    assign neg          = r_flags.neg;
    assign carry        = r_flags.carry;
    assign ovf          = r_flags.ovf;
    assign branch_taken = r_flags.branch_taken;
    assign illegal      = r_flags.illegal;

endmodule : ula_pipe
`default_nettype wire

// File: tb/tb_ula_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ula_pipe
// Description : Scoreboard bench for ula_pipe (WIDTH=32), directed + random.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ula_pipe;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero, neg, carry, ovf, branch_taken, illegal;

    int n_total = 0;
    int n_pass  = 0;
    int n_in    = 0;
    int n_out   = 0;
    logic [37:0] sb[$];
    logic        rand_on = 1'b0;
    logic        saw_in_ready_low = 1'b0;

    ula_pipe #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op           (op),
        .a            (a),
        .b            (b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .zero         (zero),
        .neg          (neg),
        .carry        (carry),
        .ovf          (ovf),
        .branch_taken (branch_taken),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: {result, zero, neg, carry, ovf, branch_taken, illegal}
    function automatic logic [37:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        logic        c, v, br, il;
        longint      sx, sy, ss;
        longint      ux, uy, us;
        int          sh;
        r = '0; c = 0; v = 0; br = 0; il = 0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        sh = int'(y[4:0]);
        case (o)
            4'd0: begin us = ux + uy; r = us[31:0]; c = us[32]; ss = sx + sy;
                        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648); end
            4'd1: begin r = x - y; c = (x < y); ss = sx - sy;
                        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648); end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = (sx < sy) ? 32'd1 : 32'd0;
            4'd6: r = (ux < uy) ? 32'd1 : 32'd0;
            4'd7: r = x << sh;
            4'd8: r = x >> sh;
            4'd9: begin ss = sx >>> sh; r = ss[31:0]; end
            4'd10: begin br = (x == y); r = {31'd0, br}; end
            4'd11: begin br = (x != y); r = {31'd0, br}; end
            4'd12: begin br = (sx < sy); r = {31'd0, br}; end
            4'd13: r = x;
            4'd14: r = y;
            default: il = 1'b1;
        endcase
        return {r, (r == 32'd0), r[31], c, v, br, il};
    endfunction

    // Scoreboard monitor: every valid output cycle is compared with the head
    // entry; the head is retired only when the output transfer actually happens.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {26'd0, result, zero, neg, carry, ovf, branch_taken, illegal}, 64'd0);
            end else begin
                chk("out_vs_scoreboard", {26'd0, result, zero, neg, carry, ovf, branch_taken, illegal}, {26'd0, sb[0]});
                if (out_ready) begin
                    void'(sb.pop_front());
                    n_out++;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one request; caller is positioned #1 after a rising edge.
    task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic [37:0] exp);
        int k;
        in_valid = 1'b1; op = o; a = x; b = y;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            chk("send_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        sb.push_back(exp);
        n_in++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        out_ready = 1'b1;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  op_r;
        logic [31:0] a_r, b_r;

        rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_outputs", {26'd0, result, zero, neg, carry, ovf, branch_taken, illegal}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Latency from an empty pipeline: result visible two cycles after accept cycle.
        send(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, {32'h0000_0000, 6'b101000});
        @(negedge clk);
        chk("latency_cycle1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("latency_cycle2", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        // Directed vectors, back to back
        send(4'd0,  32'h7FFF_FFFF, 32'h0000_0001, {32'h8000_0000, 6'b010100});
        send(4'd1,  32'h0000_0003, 32'h0000_0005, {32'hFFFF_FFFE, 6'b011000});
        send(4'd1,  32'h0000_0005, 32'h0000_0003, {32'h0000_0002, 6'b000000});
        send(4'd5,  32'hFFFF_FFFF, 32'h0000_0001, {32'h0000_0001, 6'b000000});
        send(4'd6,  32'hFFFF_FFFF, 32'h0000_0001, {32'h0000_0000, 6'b100000});
        send(4'd9,  32'h8000_0000, 32'h0000_0024, {32'hF800_0000, 6'b010000});
        send(4'd7,  32'h0000_0001, 32'h0000_001F, {32'h8000_0000, 6'b010000});
        send(4'd8,  32'h8000_0000, 32'h0000_0021, {32'h4000_0000, 6'b000000});
        send(4'd10, 32'h0000_1234, 32'h0000_1234, {32'h0000_0001, 6'b000010});
        send(4'd11, 32'h0000_0001, 32'h0000_0002, {32'h0000_0001, 6'b000010});
        send(4'd12, 32'h0000_0005, 32'hFFFF_FFFB, {32'h0000_0000, 6'b100000});
        send(4'd15, 32'h0000_0005, 32'h0000_0007, {32'h0000_0000, 6'b100001});
        send(4'd14, 32'h0000_0000, 32'h8000_0001, {32'h8000_0001, 6'b010000});
        send(4'd2,  32'h0000_F0F0, 32'h0000_FF00, {32'h0000_F000, 6'b000000});
        drain();

        // Eight back-to-back requests with the consumer stalled for four cycles
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    a_r = 32'(i * 3 + 1);
                    b_r = 32'(i);
                    send(4'd0, a_r, b_r, model(4'd0, a_r, b_r));
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    if (!in_ready) saw_in_ready_low = 1'b1;
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_in_ready_dropped", 64'(saw_in_ready_low), 64'd1);

        // Random ops with random backpressure
        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 40; i++) begin
            op_r = 4'($urandom_range(0, 15));
            a_r  = $urandom;
            b_r  = ($urandom_range(0, 3) == 0) ? a_r : $urandom;
            send(op_r, a_r, b_r, model(op_r, a_r, b_r));
        end
        rand_on = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();
        chk("in_out_count", 64'(n_out), 64'(n_in));

        // Reset with two requests in flight
        out_ready = 1'b0;
        send(4'd13, 32'hDEAD_BEEF, 32'h0, model(4'd13, 32'hDEAD_BEEF, 32'h0));
        send(4'd13, 32'hCAFE_F00D, 32'h0, model(4'd13, 32'hCAFE_F00D, 32'h0));
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_outputs", {26'd0, result, zero, neg, carry, ovf, branch_taken, illegal}, 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("post_reset_no_stale", 64'(out_valid), 64'd0);
        end
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        send(4'd0, 32'h0000_0002, 32'h0000_0003, {32'h0000_0005, 6'b000000});
        @(negedge clk);
        chk("post_reset_lat1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("post_reset_lat2", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ula_pipe
`default_nettype wire
